// File: rtl/axis_eth_rx_filter.sv
// rtl/axis_eth_rx_filter.sv - first-beat MAC/EtherType frame filter with stats
// Optional broadcast acceptance: define AXIS_ETH_RX_FILTER_BCAST_EN
module axis_eth_rx_filter #(
  parameter int COUNTER_WIDTH   = 32,
  parameter int CHECK_ETHERTYPE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tvalid,
  input  logic [127:0]             s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic [15:0]              s_axis_tkeep,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [127:0]             m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [15:0]              m_axis_tkeep,
  input  logic                     cfg_enable,
  input  logic [47:0]              cfg_mac_addr,
  input  logic [15:0]              cfg_ethertype,
  output logic [COUNTER_WIDTH-1:0] cnt_passed,
  output logic [COUNTER_WIDTH-1:0] cnt_dropped,
  output logic [COUNTER_WIDTH-1:0] cnt_runt
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                   state_q;
  logic                     m_valid_q;
  logic [127:0]             m_data_q;
  logic                     m_last_q;
  logic [15:0]              m_keep_q;
  logic [COUNTER_WIDTH-1:0] cnt_passed_q;
  logic [COUNTER_WIDTH-1:0] cnt_dropped_q;
  logic [COUNTER_WIDTH-1:0] cnt_runt_q;

  logic [47:0] dest_mac;
  logic [15:0] ethertype;
  logic [4:0]  keep_cnt;
  logic        is_bcast;
  logic        runt;
  logic        mac_ok;
  logic        type_ok;
  logic        check_type;
  logic        out_free;
  logic        accept;

  // Header fields in wire order: byte 0 is the MSB of the MAC address
  assign dest_mac  = {s_axis_tdata[7:0],   s_axis_tdata[15:8],  s_axis_tdata[23:16],
                      s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};
  assign ethertype = {s_axis_tdata[103:96], s_axis_tdata[111:104]};

  // Count valid bytes of the beat for runt detection
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      keep_cnt = keep_cnt + {4'd0, s_axis_tkeep[i]};
    end
  end

`ifdef AXIS_ETH_RX_FILTER_BCAST_EN
  assign is_bcast = (dest_mac == 48'hFFFF_FFFF_FFFF);
`else
  assign is_bcast = 1'b0;
`endif

  // A frame shorter than dest+src+type cannot be classified, so it is a runt
  assign runt       = s_axis_tlast && (keep_cnt < 5'd14);
  assign check_type = (CHECK_ETHERTYPE != 0);
  assign mac_ok     = !cfg_enable || (dest_mac == cfg_mac_addr) || is_bcast;
  assign type_ok    = !cfg_enable || !check_type || (ethertype == cfg_ethertype);

  // DROP never writes the output register, so it need not wait for downstream
  assign out_free      = !m_valid_q || m_axis_tready;
  assign s_axis_tready = rst_n && ((state_q == DROP) || out_free);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Frame state, output register and statistics counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      m_keep_q      <= '0;
      cnt_passed_q  <= '0;
      cnt_dropped_q <= '0;
      cnt_runt_q    <= '0;
    end else begin
      if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (runt) begin
              cnt_runt_q <= cnt_runt_q + COUNTER_WIDTH'(1);
            end else if (mac_ok && type_ok) begin
              m_valid_q <= 1'b1;
              m_data_q  <= s_axis_tdata;
              m_last_q  <= s_axis_tlast;
              m_keep_q  <= s_axis_tkeep;
              if (s_axis_tlast) begin
                cnt_passed_q <= cnt_passed_q + COUNTER_WIDTH'(1);
              end else begin
                state_q <= PASS;
              end
            end else if (s_axis_tlast) begin
              cnt_dropped_q <= cnt_dropped_q + COUNTER_WIDTH'(1);
            end else begin
              state_q <= DROP;
            end
          end
          PASS: begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_axis_tdata;
            m_last_q  <= s_axis_tlast;
            m_keep_q  <= s_axis_tkeep;
            if (s_axis_tlast) begin
              cnt_passed_q <= cnt_passed_q + COUNTER_WIDTH'(1);
              state_q      <= IDLE;
            end
          end
          DROP: begin
            if (s_axis_tlast) begin
              cnt_dropped_q <= cnt_dropped_q + COUNTER_WIDTH'(1);
              state_q       <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tkeep  = m_keep_q;
  assign cnt_passed    = cnt_passed_q;
  assign cnt_dropped   = cnt_dropped_q;
  assign cnt_runt      = cnt_runt_q;

endmodule

// File: tb/tb_axis_eth_rx_filter.sv
// tb/tb_axis_eth_rx_filter.sv - directed self-checking bench for axis_eth_rx_filter
module tb_axis_eth_rx_filter;

  localparam logic [47:0] MAC = 48'h0200_0000_0001;
  localparam logic [15:0] ETY = 16'h88B5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_tready, s_tvalid, s_tlast;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         m_tready, m_tvalid, m_tlast;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         cfg_enable;
  logic [47:0]  cfg_mac;
  logic [15:0]  cfg_type;
  logic [31:0]  cnt_passed, cnt_dropped, cnt_runt;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    ep = 0, ed = 0, er = 0;
  logic  stall_mode = 1'b0;
  logic  stall_chk = 1'b0;

  always #5 clk = ~clk;

  axis_eth_rx_filter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tready (s_tready),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tkeep  (s_tkeep),
    .m_axis_tready (m_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tkeep  (m_tkeep),
    .cfg_enable    (cfg_enable),
    .cfg_mac_addr  (cfg_mac),
    .cfg_ethertype (cfg_type),
    .cnt_passed    (cnt_passed),
    .cnt_dropped   (cnt_dropped),
    .cnt_runt      (cnt_runt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Downstream ready: always 1, or the 1,0,0,1 pattern in stall mode
  initial begin
    logic pat [4];
    int   ph;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ph = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (stall_mode) begin
        m_tready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        m_tready = 1'b1;
        ph = 0;
      end
    end
  end

  // Output monitor: scoreboard, hold-while-stalled and backpressure checks
  initial begin
    logic         prev_v, prev_r;
    logic [127:0] prev_d;
    beat_t        b;
    prev_v = 1'b0;
    prev_r = 1'b1;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_v && !prev_r) begin
        check("hold_valid", 128'(m_tvalid), 128'd1);
        check("hold_data", m_tdata, prev_d);
      end
      if (stall_chk && m_tvalid && !m_tready) begin
        check("stall_sready", 128'(s_tready), 128'd0);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_tdata, 128'd0 - 128'd1);
        end else begin
          b = exp_q.pop_front();
          check("out_data", m_tdata, b.d);
          check("out_keep", 128'(m_tkeep), 128'(b.k));
          check("out_last", 128'(m_tlast), 128'(b.l));
        end
      end
      prev_v = m_tvalid;
      prev_r = m_tready;
      prev_d = m_tdata;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_passed"}, 128'(cnt_passed), 128'(ep));
    check({tag, "_dropped"}, 128'(cnt_dropped), 128'(ed));
    check({tag, "_runt"}, 128'(cnt_runt), 128'(er));
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                           input logic lat_chk, input logic must_rdy);
    logic r;
    int   waited;
    waited = 0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tkeep = k;
    s_tlast = l;
    forever begin
      @(negedge clk);
      r = s_tready;
      @(posedge clk);
      #1;
      if (r) break;
      waited++;
      if (waited > 100) begin
        check("sready_timeout", 128'd0, 128'd1);
        break;
      end
    end
    s_tvalid = 1'b0;
    if (must_rdy) check("sready_immediate", 128'(waited), 128'd0);
    if (lat_chk) begin
      check("lat_valid", 128'(m_tvalid), 128'd1);
      check("lat_data", m_tdata, d);
    end
  endtask

  function automatic logic [127:0] hdr(input logic [47:0] mac, input logic [15:0] et,
                                       input logic [31:0] seed);
    logic [127:0] d;
    d = {4{seed}};
    for (int i = 0; i < 6; i++) d[8*i +: 8] = mac[47-8*i -: 8];
    for (int i = 6; i < 12; i++) d[8*i +: 8] = 8'hA0 + 8'(i);
    d[103:96] = et[15:8];
    d[111:104] = et[7:0];
    return d;
  endfunction

  task automatic send_frame(input logic [47:0] mac, input logic [15:0] et, input int n,
                            input logic [15:0] keep_last, input logic pass,
                            input logic [31:0] seed, input logic lat_chk,
                            input logic must_rdy);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = (k == 0) ? hdr(mac, et, seed) : {4{seed + 32'(k)}};
      b.l = (k == n - 1);
      b.k = b.l ? keep_last : 16'hFFFF;
      if (pass) exp_q.push_back(b);
      send_beat(b.d, b.k, b.l, lat_chk, must_rdy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tlast = 1'b0;
    cfg_enable = 1'b1;
    cfg_mac = MAC;
    cfg_type = ETY;
    idle(3);
    check("rst_mvalid", 128'(m_tvalid), 128'd0);
    check("rst_mdata", m_tdata, 128'd0);
    check("rst_sready", 128'(s_tready), 128'd0);
    check_cnts("rst");
    rst_n = 1'b1;
    idle(2);

    // Matching 4-beat frame, one-cycle latency per beat
    send_frame(MAC, ETY, 4, 16'hFFFF, 1'b1, 32'h1000_0000, 1'b1, 1'b1);
    ep++;
    idle(3);
    check_cnts("pass4");

    // Wrong destination: consumed without backpressure, nothing out
    send_frame(48'h0200_0000_0002, ETY, 3, 16'h00FF, 1'b0, 32'h2000_0000, 1'b0, 1'b1);
    ed++;
    idle(3);
    check_cnts("drop3");

    // Runt boundary: 12 and 13 bytes are runts, 14 bytes passes
    send_frame(MAC, ETY, 1, 16'h0FFF, 1'b0, 32'h3000_0000, 1'b0, 1'b1);
    er++;
    send_frame(MAC, ETY, 1, 16'h1FFF, 1'b0, 32'h3100_0000, 1'b0, 1'b1);
    er++;
    send_frame(MAC, ETY, 1, 16'h3FFF, 1'b1, 32'h3200_0000, 1'b1, 1'b1);
    ep++;
    idle(3);
    check_cnts("runt");

    // EtherType mismatch
    send_frame(MAC, 16'h0800, 1, 16'hFFFF, 1'b0, 32'h4000_0000, 1'b0, 1'b1);
    ed++;
    idle(3);
    check_cnts("etype");

    // Stalled 8-beat frame
    stall_mode = 1'b1;
    stall_chk = 1'b1;
    send_frame(MAC, ETY, 8, 16'h0001, 1'b1, 32'h5000_0000, 1'b0, 1'b0);
    ep++;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("stall_drain", 128'(exp_q.size()), 128'd0);
    stall_chk = 1'b0;
    stall_mode = 1'b0;
    idle(3);
    check_cnts("stall");

    // Broadcast, filtered then promiscuous
`ifdef AXIS_ETH_RX_FILTER_BCAST_EN
    send_frame(48'hFFFF_FFFF_FFFF, ETY, 2, 16'hFFFF, 1'b1, 32'h6000_0000, 1'b0, 1'b0);
    ep++;
`else
    send_frame(48'hFFFF_FFFF_FFFF, ETY, 2, 16'hFFFF, 1'b0, 32'h6000_0000, 1'b0, 1'b0);
    ed++;
`endif
    idle(3);
    check_cnts("bcast");
    cfg_enable = 1'b0;
    send_frame(48'hFFFF_FFFF_FFFF, ETY, 2, 16'hFFFF, 1'b1, 32'h6100_0000, 1'b0, 1'b0);
    ep++;
    send_frame(48'h1234_5678_9ABC, 16'h0800, 2, 16'h00FF, 1'b1, 32'h6200_0000, 1'b0, 1'b0);
    ep++;
    idle(3);
    check_cnts("promisc");
    cfg_enable = 1'b1;

    // Reset during beat 2 of a passing frame
    begin
      beat_t b;
      b.d = hdr(MAC, ETY, 32'h7000_0000);
      b.k = 16'hFFFF;
      b.l = 1'b0;
      exp_q.push_back(b);
      send_beat(b.d, b.k, b.l, 1'b0, 1'b0);
      s_tvalid = 1'b1;
      s_tdata = {4{32'h7000_0001}};
      s_tlast = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_tvalid = 1'b0;
      ep = 0;
      ed = 0;
      er = 0;
      check("midrst_mvalid", 128'(m_tvalid), 128'd0);
      check_cnts("midrst");
    end
    send_frame(MAC, ETY, 2, 16'h0FFF, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    ep++;
    send_frame(48'h0200_0000_0003, ETY, 1, 16'hFFFF, 1'b0, 32'h8100_0000, 1'b0, 1'b0);
    ed++;
    idle(5);
    check_cnts("postrst");
    check("final_drain", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_eth_rx_filter.md
Name: axis_eth_rx_filter

Overview:
Single-clock AXI4-Stream frame filter placed directly downstream of the 40G Ethernet RX AXI4-Stream output (128-bit data, 16-bit keep, preamble/FCS already stripped). Inspects the first beat of each frame (destination MAC, EtherType), forwards matching frames unchanged and silently drops all others. Exposes pass/drop/runt counters for the status logic.

Parameters:
COUNTER_WIDTH, 32, width of each statistics counter
CHECK_ETHERTYPE, 1, 1 = EtherType must equal cfg_ethertype; 0 = EtherType ignored

Ports:
clk  in  1  block clock (the RX XLGMII/AXIS clock)
rst_n  in  1  reset, synchronous, active-low
s_axis_tready  out  1  upstream ready
s_axis_tvalid  in  1  upstream valid
s_axis_tdata  in  128  upstream data; byte n = tdata[8n+7:8n], byte 0 first on the wire
s_axis_tlast  in  1  upstream end of frame
s_axis_tkeep  in  16  upstream byte enables, contiguous from bit 0
m_axis_tready  in  1  downstream ready
m_axis_tvalid  out  1  downstream valid
m_axis_tdata  out  128  downstream data
m_axis_tlast  out  1  downstream end of frame
m_axis_tkeep  out  16  downstream byte enables
cfg_enable  in  1  0 = promiscuous (pass all non-runt frames)
cfg_mac_addr  in  48  station MAC; [47:40] = wire byte 0
cfg_ethertype  in  16  accepted EtherType; [15:8] = wire byte 12
cnt_passed  out  COUNTER_WIDTH  frames forwarded
cnt_dropped  out  COUNTER_WIDTH  frames dropped by address/type mismatch
cnt_runt  out  COUNTER_WIDTH  frames dropped as runts

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low. All state is sampled on the rising edge of clk.
- Reset (rst_n=0 at a clk edge): state=IDLE, m_axis_tvalid=0, m_axis_tdata/tlast/tkeep=0, all counters=0, s_axis_tready=0 during reset.
- Output stage: a single register. s_axis_tready = !m_axis_tvalid || m_axis_tready in IDLE/PASS; s_axis_tready = 1 in DROP. Forwarded beats appear at the output 1 cycle after acceptance. Throughput is one beat per cycle with no bubbles when m_axis_tready=1.
- m_axis_t* are held stable while m_axis_tvalid=1 and m_axis_tready=0.
- States:
  - IDLE: awaiting first beat of a frame. On accepted beat, evaluate:
    - runt = tlast && popcount(tkeep) < 14
    - mac_ok = !cfg_enable || bytes0..5 == cfg_mac_addr
    - type_ok = !cfg_enable || !CHECK_ETHERTYPE || {byte12,byte13} == cfg_ethertype
  - Evaluation outcomes:
    - runt: drop beat, cnt_runt++, stay IDLE.
    - mac_ok && type_ok: load beat into output register. If tlast, cnt_passed++ and stay IDLE; else go to PASS.
    - otherwise: drop beat. If tlast, cnt_dropped++ and stay IDLE; else go to DROP.
  - PASS: forward every accepted beat. On accepted tlast, cnt_passed++ and go to IDLE.
  - DROP: consume and discard beats. On accepted tlast, cnt_dropped++ and go to IDLE.
- cfg_* are sampled only on the first beat; changes mid-frame do not affect the current frame.
- Counters wrap from 2^COUNTER_WIDTH-1 to 0. At most one counter increments per cycle.
- Frame counters for passed frames increment when tlast is accepted at the input, not when it leaves the output.
- Reset mid-frame: state returns to IDLE and any held output beat is discarded. Upstream is reset in the same domain, so no partial-frame resync is performed.
- tvalid=0 between beats (gaps) are allowed in any state; the state is held.

Optional Feature:
AXIS_ETH_RX_FILTER_BCAST_EN:
- Defined: mac_ok is also true when bytes 0..5 == FF:FF:FF:FF:FF:FF. The EtherType check is still applied.
- Undefined: broadcast frames are treated like any other non-matching address and are dropped when cfg_enable=1.

Test Plan:
- cfg_enable=1, mac=02:00:00:00:00:01, type=0x88B5; send a 4-beat frame with matching header, m_axis_tready=1 -> identical 4 beats out, each 1 cycle later; cnt_passed=1.
- Same cfg; 3-beat frame with dest 02:00:00:00:00:02 -> no output beats, s_axis_tready=1 throughout; cnt_dropped=1.
- Single beat, tlast=1, tkeep=0x0FFF (12 bytes) -> dropped; cnt_runt=1. A matching single beat with tkeep=0x3FFF -> forwarded; cnt_passed increments.
- Matching 8-beat frame with m_axis_tready toggling 1,0,0,1,... -> output data stable while stalled, no beat lost or duplicated, s_axis_tready=0 while the output register is full and stalled.
- Broadcast dest FF:FF:FF:FF:FF:FF with type 0x88B5 -> passed with AXIS_ETH_RX_FILTER_BCAST_EN defined, dropped without it; cfg_enable=0 -> passed in both builds.
- Assert rst_n=0 for 1 cycle during beat 2 of a passing frame -> m_axis_tvalid=0 and counters=0 the next cycle; the next full frame is filtered normally.
